operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register operand fetch with pending-write scoreboard.
// Ports: clk/rst (async, active-low); decode in* (valid/ready);
//   rfRead* to the register file; wb* writeback; out* to execute; flush.
// Build option: OPF_BYPASS_EN forwards the current writeback to operands.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module operand_fetch_stage #(
  parameter int SIZE  = 16,
  parameter int WIDTH = `WORD_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [$clog2(SIZE)-1:0] inSrcA,
  input  logic [$clog2(SIZE)-1:0] inSrcB,
  input  logic [$clog2(SIZE)-1:0] inDst,
  input  logic                    inDstWrite,
  output logic [$clog2(SIZE)-1:0] rfReadAddr1,
  output logic [$clog2(SIZE)-1:0] rfReadAddr2,
  input  logic [WIDTH-1:0]        rfReadData1,
  input  logic [WIDTH-1:0]        rfReadData2,
  input  logic                    wbEnable,
  input  logic [$clog2(SIZE)-1:0] wbAddr,
  input  logic [WIDTH-1:0]        wbData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [WIDTH-1:0]        outOpA,
  output logic [WIDTH-1:0]        outOpB,
  output logic [$clog2(SIZE)-1:0] outDst,
  output logic                    outDstWrite,
  input  logic                    flush
);

  localparam int AW = $clog2(SIZE);

  logic [SIZE-1:0] pending;
  logic [SIZE-1:0] pending_next;
  logic            byp_a;
  logic            byp_b;
  logic            haz_a;
  logic            haz_b;
  logic            waw;
  logic            accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign rfReadAddr1 = inSrcA;
  assign rfReadAddr2 = inSrcB;

`ifdef OPF_BYPASS_EN
  assign byp_a = wbEnable && (wbAddr == inSrcA)
              && (inSrcA != '0);
  assign byp_b = wbEnable && (wbAddr == inSrcB)
              && (inSrcB != '0);
`else
  // Without forwarding a matching source waits
  // one cycle for the register file to update.
  logic unused_wb;
  assign unused_wb = ^wbData;
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign haz_a = (inSrcA != '0) && pending[inSrcA]
              && !byp_a;
  assign haz_b = (inSrcB != '0) && pending[inSrcB]
              && !byp_b;
  // Writeback does not release a WAW stall early:
  // set and clear of one bit never coincide.
  assign waw = inDstWrite && (inDst != '0)
            && pending[inDst];

  assign inReady = rst && (!outValid || outReady)
                && !flush && !haz_a && !haz_b && !waw;
  assign accept = inValid && inReady;

  always_comb begin
    op_a = rfReadData1;
    if (inSrcA == '0) op_a = '0;
    else if (byp_a) op_a = wbData;
  end

  always_comb begin
    op_b = rfReadData2;
    if (inSrcB == '0) op_b = '0;
    else if (byp_b) op_b = wbData;
  end

  always_comb begin
    pending_next = pending;
    if (wbEnable && (wbAddr != '0))
      pending_next[wbAddr] = 1'b0;
    if (flush && outValid && outDstWrite)
      pending_next[outDst] = 1'b0;
    if (accept && inDstWrite && (inDst != '0))
      pending_next[inDst] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid    <= 1'b0;
      outOpA      <= '0;
      outOpB      <= '0;
      outDst      <= '0;
      outDstWrite <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid    <= 1'b1;
      outOpA      <= op_a;
      outOpB      <= op_b;
      outDst      <= inDst;
      outDstWrite <= inDstWrite;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;

endmodule
